// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite command master: response codes, FSM states,
// and the command/response records carried between the ports and the FSM.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Record widths; the master supports address widths up to CMD_ADDR_W.
  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

  typedef struct packed {
    logic                    write;
    logic [CMD_ADDR_W-1:0]   addr;
    logic [CMD_DATA_W-1:0]   wdata;
    logic [CMD_DATA_W/8-1:0] wstrb;
  } cmd_t;

  typedef struct packed {
    logic [CMD_DATA_W-1:0] rdata;
    logic [1:0]            resp;
    logic                  timeout;
  } rsp_t;

  function automatic logic is_bus_state(state_t s);
    return (s == WR) || (s == WR_RESP) || (s == RD_ADDR) || (s == RD_DATA);
  endfunction

endpackage

// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and a register slave.
interface axi_lite_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/txn_timeout_cnt.sv
// Per-transaction watchdog: expired is high in the cycle the count would
// reach TIMEOUT_CYCLES-1, so the FSM leaves on that same edge.
module txn_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES - 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = enable && (count_reg == LAST);
endmodule

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: one command in, one bus transaction,
// one response out, with a watchdog that abandons a dead bus.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic                            err_sticky,
  axi_lite_cmd_master_if.master           m_axi
);
  state_t state_reg, state_next;
  cmd_t   cmd_reg, cmd_next;
  rsp_t   rsp_reg, rsp_next;
  logic   aw_done_reg, aw_done_next;
  logic   w_done_reg, w_done_next;
  logic   err_sticky_reg;
  logic   cnt_clear, cnt_enable, cnt_expired;

  txn_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (ACLK),
    .srst    (ARESET),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (cnt_expired)
  );

  assign cnt_enable = is_bus_state(state_reg);

  assign cmd_ready   = (state_reg == IDLE);
  assign rsp_valid   = (state_reg == RSP);
  assign rsp_rdata   = rsp_reg.rdata;
  assign rsp_resp    = rsp_reg.resp;
  assign rsp_timeout = rsp_reg.timeout;
  assign err_sticky  = err_sticky_reg;

  assign m_axi.awaddr  = cmd_reg.addr[C_M_AXI_ADDR_WIDTH-1:0];
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = (state_reg == WR) && !aw_done_reg;
  assign m_axi.wdata   = cmd_reg.wdata;
  assign m_axi.wstrb   = cmd_reg.wstrb;
  assign m_axi.wvalid  = (state_reg == WR) && !w_done_reg;
  assign m_axi.bready  = (state_reg == WR_RESP);
  assign m_axi.araddr  = cmd_reg.addr[C_M_AXI_ADDR_WIDTH-1:0];
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = (state_reg == RD_ADDR);
  assign m_axi.rready  = (state_reg == RD_DATA);

  always_comb begin
    state_next   = state_reg;
    cmd_next     = cmd_reg;
    rsp_next     = rsp_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    cnt_clear    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          cmd_next = '{write: cmd_write,
                       addr:  CMD_ADDR_W'({cmd_addr[C_M_AXI_ADDR_WIDTH-1:2], 2'b00}),
                       wdata: cmd_wdata,
                       wstrb: cmd_wstrb};
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          cnt_clear    = 1'b1;
          state_next   = cmd_write ? WR : RD_ADDR;
        end
      end
      WR: begin
        aw_done_next = aw_done_reg || m_axi.awready;
        w_done_next  = w_done_reg || m_axi.wready;
        if (cnt_expired) begin
          rsp_next   = '{rdata: '0, resp: RESP_SLVERR, timeout: 1'b1};
          state_next = RSP;
        end else if (aw_done_next && w_done_next) begin
          state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        // A B handshake coinciding with expiry still wins.
        if (m_axi.bvalid) begin
          rsp_next   = '{rdata: '0, resp: m_axi.bresp, timeout: 1'b0};
          state_next = RSP;
        end else if (cnt_expired) begin
          rsp_next   = '{rdata: '0, resp: RESP_SLVERR, timeout: 1'b1};
          state_next = RSP;
        end
      end
      RD_ADDR: begin
        if (cnt_expired) begin
          rsp_next   = '{rdata: '0, resp: RESP_SLVERR, timeout: 1'b1};
          state_next = RSP;
        end else if (m_axi.arready) begin
          state_next = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axi.rvalid) begin
          rsp_next   = '{rdata: m_axi.rdata, resp: m_axi.rresp, timeout: 1'b0};
          state_next = RSP;
        end else if (cnt_expired) begin
          rsp_next   = '{rdata: '0, resp: RESP_SLVERR, timeout: 1'b1};
          state_next = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg      <= IDLE;
      cmd_reg        <= '0;
      rsp_reg        <= '0;
      aw_done_reg    <= 1'b0;
      w_done_reg     <= 1'b0;
      err_sticky_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cmd_reg     <= cmd_next;
      rsp_reg     <= rsp_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      if (state_next == RSP && state_reg != RSP && rsp_next.resp != RESP_OKAY) begin
        err_sticky_reg <= 1'b1;
      end
    end
  end
endmodule
